// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks (receiver, transmitter, baud
// generator): receiver FSM state encoding, default frame geometry and the
// baud divider constant for a 100 MHz clock at 9600 baud with 16x oversampling.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Default frame geometry: br_tick pulses per bit and payload bits per frame.
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

  // Baud generator divider: clk cycles between consecutive br_tick pulses.
  localparam int CLK_HZ   = 100_000_000;
  localparam int BAUD     = 9600;
  localparam int BAUD_DIV = CLK_HZ / BAUD / DEF_OVERSAMPLE;  // 651

  // Falling edge on a synchronized line: was high, is now low.
  function automatic logic is_fall(input logic prev, input logic cur);
    return prev & ~cur;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for a single asynchronous input. Both flops reset to
// RESET_VAL so an idle-high serial line does not produce a false edge when
// reset is released. Reusable for any other asynchronous level input.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high reset
//   async_in in   input asynchronous to clk
//   sync_out out  async_in delayed by two clk, safe to use in the clk domain
// -----------------------------------------------------------------------------
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  // First stage may go metastable; only the second stage is used downstream.
  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta     <= RESET_VAL;
      sync_out <= RESET_VAL;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. Uses the shared 16x-oversampled br_tick from the baud
// generator: the start bit is re-checked at its mid-point, then each data bit
// and the stop bit are sampled one full bit period apart (LSB first).
// A byte is published on rx_data with a one-clk rx_done strobe only when the
// stop bit reads 1; otherwise the byte is discarded.
//
// Optional build macro: UART_RX_FRAME_ERR_EN
//   When defined, a frame_err output pulses for one clk when the stop bit
//   samples 0, at the cycle rx_done would otherwise have pulsed.
//
// Ports:
//   clk       in   system clock (100 MHz)
//   reset     in   asynchronous, active-high reset
//   br_tick   in   one-clk pulse at OVERSAMPLE x baud
//   rx        in   serial line, idle high, asynchronous to clk
//   rx_data   out  last correctly received byte, stable between rx_done pulses
//   rx_done   out  one-clk pulse when rx_data updates
//   frame_err out  one-clk pulse on a bad stop bit (UART_RX_FRAME_ERR_EN only)
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 br_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic                 frame_err
`endif
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Start bit is checked half a bit in; later samples are one bit apart, so
  // every sample lands near the middle of its bit.
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic rx_sync;
  logic rx_prev;

  uart_rx_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (rx),
    .sync_out (rx_sync)
  );

  // rx_prev resets high so the idle line never looks like a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_prev <= 1'b1;
    else       rx_prev <= rx_sync;
  end

  // ---------------------------------------------------------------------------
  // FSM and datapath registers
  // ---------------------------------------------------------------------------
  rx_state_t              state,     state_nxt;
  logic [TICK_W-1:0]      tick_cnt,  tick_cnt_nxt;
  logic [BIT_W-1:0]       bit_cnt,   bit_cnt_nxt;
  logic [DATA_BITS-1:0]   shift_reg, shift_reg_nxt;
  logic [DATA_BITS-1:0]   rx_data_nxt;
  logic                   rx_done_nxt;
`ifdef UART_RX_FRAME_ERR_EN
  logic                   frame_err_nxt;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_reg_nxt;
      rx_data   <= rx_data_nxt;
      rx_done   <= rx_done_nxt;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err <= frame_err_nxt;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // Counters only move on br_tick, so without ticks everything holds.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // forgets an assignment would otherwise infer a latch.
    state_nxt     = state;
    tick_cnt_nxt  = tick_cnt;
    bit_cnt_nxt   = bit_cnt;
    shift_reg_nxt = shift_reg;
    rx_data_nxt   = rx_data;
    rx_done_nxt   = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    frame_err_nxt = 1'b0;
`endif

    case (state)
      // Only a high-to-low transition arms the receiver; a line that stays
      // low (break) never restarts it.
      IDLE: begin
        if (is_fall(rx_prev, rx_sync)) begin
          state_nxt    = START;
          tick_cnt_nxt = '0;
        end
      end

      // Re-check the line at the start-bit mid-point to reject short glitches.
      START: begin
        if (br_tick) begin
          if (tick_cnt == TICK_MID) begin
            tick_cnt_nxt = '0;
            if (!rx_sync) begin
              state_nxt   = DATA;
              bit_cnt_nxt = '0;
            end else begin
              state_nxt   = IDLE;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + TICK_W'(1);
          end
        end
      end

      // One sample per bit period, shifted in from the top so the first bit
      // received ends up in bit 0.
      DATA: begin
        if (br_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_nxt  = '0;
            shift_reg_nxt = {rx_sync, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              state_nxt   = STOP;
            end else begin
              bit_cnt_nxt = bit_cnt + BIT_W'(1);
            end
          end else begin
            tick_cnt_nxt = tick_cnt + TICK_W'(1);
          end
        end
      end

      // Publish the byte only if the stop bit is high. Returning to IDLE at the
      // stop-bit mid-point lets a back-to-back start edge be caught.
      STOP: begin
        if (br_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_nxt = '0;
            state_nxt    = IDLE;
            if (rx_sync) begin
              rx_data_nxt = shift_reg;
              rx_done_nxt = 1'b1;
            end
`ifdef UART_RX_FRAME_ERR_EN
            frame_err_nxt = ~rx_sync;
`endif
          end else begin
            tick_cnt_nxt = tick_cnt + TICK_W'(1);
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. Counterpart of the existing UART transmitter.
- Consumes the shared 16x-oversampled br_tick from the baudrate generator and reconstructs bytes from the serial line.
- Sits beside the transmitter under the UART top: rx pin in, parallel byte plus done strobe out to the user logic.

Parameters:
- OVERSAMPLE, 16, br_tick pulses per bit period; counter width is $clog2(OVERSAMPLE).
- DATA_BITS, 8, payload bits per frame, sent LSB first.

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-high reset
- br_tick  input  1  one-clk pulse at 16x baud (9600 baud: every 651 clk)
- rx  input  1  serial line, idle high, asynchronous to clk
- rx_data  output  DATA_BITS  last correctly received byte
- rx_done  output  1  one-clk pulse when rx_data updates
- frame_err  output  1  present only with UART_RX_FRAME_ERR_EN

Behaviour:
- Reset (async, active-high):
  - state=IDLE; tick_cnt=0; bit_cnt=0; shift_reg=0.
  - rx_data=0; rx_done=0; frame_err=0.
  - Both synchronizer flops and rx_prev reset to 1.
- Input conditioning:
  - rx passes through a 2-flop synchronizer to give rx_sync.
  - rx_prev holds rx_sync delayed by one clk.
  - All decisions use rx_sync only.
- FSM (registered state, combinational next-state):
  - IDLE: on a falling edge (rx_prev=1, rx_sync=0), go to START and set tick_cnt=0. A steady low level does not arm the FSM.
  - START: on each br_tick, tick_cnt++. When tick_cnt==OVERSAMPLE/2-1 (7):
    - rx_sync=0: go to DATA, tick_cnt=0, bit_cnt=0.
    - rx_sync=1: glitch; return to IDLE with no output.
  - DATA: on each br_tick, tick_cnt++. When tick_cnt==15 (bit mid-point):
    - shift_reg = {rx_sync, shift_reg[7:1]} (LSB first); tick_cnt=0.
    - If bit_cnt==DATA_BITS-1, go to STOP; otherwise bit_cnt++.
  - STOP: on br_tick with tick_cnt==15:
    - rx_sync=1: rx_data<=shift_reg, rx_done<=1, go to IDLE.
    - rx_sync=0: framing error; rx_data unchanged, rx_done stays 0, go to IDLE.
- br_tick absent: all counters and state hold.
- rx_done is high for exactly one clk. It rises at the clk edge after the br_tick that samples the stop bit, about 9.5 bit times after the start edge (about 9.5*16*651 clk plus 2 synchronizer clk).
- A new falling edge is accepted only in IDLE. Edges seen in START, DATA or STOP are sampled as data, not restarts.
- Back-to-back frames are supported: the next start edge may follow the stop-bit mid-point immediately.
- After a framing error with rx held low (break), the FSM stays in IDLE until rx returns high and then falls again.
- Reset mid-frame aborts the frame immediately. No rx_done or frame_err pulse is produced.
- rx_data stays stable between rx_done pulses.

Optional Feature:
- Macro: UART_RX_FRAME_ERR_EN.
- Defined:
  - Output frame_err exists, resets to 0.
  - Pulses high for one clk when the stop bit samples 0, at the same timing rx_done would have had.
  - rx_done and frame_err are never high together.
- Undefined:
  - No frame_err port and no register.
  - A bad stop bit silently discards the byte.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - OVERSAMPLE default (16).
  - DATA_BITS default (8).
  - Baud constant 100_000_000/9600/16.
- Sub-module uart_rx_sync: 2-flop synchronizer with reset value 1, reusable for other async inputs.
- The baudrate generator is not duplicated; the UART top feeds the same br_tick to both directions.

Test Plan:
- Reset then idle line held at 1 for 20 bit times -> rx_done never asserts; rx_data=8'h00.
- Frame 0x55 at 9600 baud -> one rx_done pulse ~9.5 bit times after the start edge; rx_data=8'h55.
- Loopback: transmitter sends 0xA3 then 0x0F back-to-back into uart_rx -> two rx_done pulses; rx_data=8'hA3, then 8'h0F.
- rx low glitch of 3 br_tick periods, then high -> FSM returns to IDLE; no rx_done; rx_data unchanged.
- Frame 0xC4 with stop bit forced 0 -> no rx_done; rx_data keeps its previous value. With UART_RX_FRAME_ERR_EN defined, frame_err pulses exactly one clk.
- Reset asserted during D4 of frame 0x81, then a clean 0x81 frame -> no output from the aborted frame; the clean frame gives rx_data=8'h81 and a single rx_done.
